doodlejump_key_poller: RTL
==========================

// Module: doodlejump_key_poller
// PURPOSE
//  Avalon-MM read master (initiator) that periodically polls the key PIO slave
//  (data register at word address 0, readdata registered, 1-cycle latency) and
//  turns the raw pushbutton bits into debounced key state plus press/release
//  pulses for the game logic. Sits between the key PIO and the doodle controller.
// PARAMETERS
//  NKEYS          2      number of key bits taken from readdata[NKEYS-1:0]
//  ADDR_W         2      width of avm_address
//  KEY_ADDR       0      word address of the PIO data register
//  POLL_CYCLES    50000  clk cycles between poll starts (1 ms at 50 MHz); >=4
//  READ_LATENCY   1      cycles from accepted read to valid avm_readdata; >=1
//  DEBOUNCE_CNT   4      consecutive equal samples required to change state; >=1
//  ACTIVE_LOW     1      1: raw bit 0 means pressed (inverted before debounce)
// PORTS
//  clk              in   1       system clock
//  reset_n          in   1       asynchronous active-low reset
//  enable           in   1       1: polling runs; 0: no new reads issued
//  avm_address      out  ADDR_W  read address, constant KEY_ADDR
//  avm_read         out  1       read request
//  avm_waitrequest  in   1       slave stall; request held while high
//  avm_readdata     in   32      read data
//  key_state        out  NKEYS   debounced state, 1 = pressed
//  key_press        out  NKEYS   1-cycle pulse per bit on debounced 0->1
//  key_release      out  NKEYS   1-cycle pulse per bit on debounced 1->0
//  sample_valid     out  1       1-cycle pulse when a sample has been captured
// BEHAVIOUR
//  Reset: avm_read=0, key_state/key_press/key_release/sample_valid=0, FSM=IDLE,
//   poll timer=0, debounce counters=0, timer_expired flag=0. Reset mid-read
//   aborts immediately; avm_read drops asynchronously.
//  Poll timer: free-running 0..POLL_CYCLES-1 while enable=1, wraps; on wrap sets
//   timer_expired (one pending only, never accumulates). Held at 0 when enable=0.
//  FSM:
//   IDLE: if timer_expired & enable -> clear flag, go REQ (avm_read=1 next cycle).
//   REQ: avm_read=1, avm_address=KEY_ADDR; stays while avm_waitrequest=1; on
//    cycle with waitrequest=0 read is accepted -> WAIT, avm_read=0 next cycle.
//   WAIT: counts READ_LATENCY-1 further cycles; readdata sampled exactly
//    READ_LATENCY cycles after the accept edge -> CAPTURE.
//   CAPTURE: raw = readdata[NKEYS-1:0] (^ {NKEYS{ACTIVE_LOW}}), sample_valid=1
//    for one cycle, debounce update, -> IDLE.
//  Timer expiry while not IDLE: flag kept; next read issues on return to IDLE.
//  enable=0 mid-transaction: transaction completes and is debounced normally.
//  Debounce per bit: if raw==key_state counter=0; else counter+1; when counter
//   reaches DEBOUNCE_CNT-1 on a differing sample, key_state flips, counter=0.
//   Counter saturates by construction (width clog2(DEBOUNCE_CNT)+1).
//  key_press/key_release assert in the cycle after CAPTURE together with the
//   updated key_state, for exactly one cycle; both zero otherwise.
//  Latency: raw change -> key_state change = DEBOUNCE_CNT polls.
// TESTING (POLL_CYCLES=10, READ_LATENCY=1, DEBOUNCE_CNT=3, ACTIVE_LOW=1)
//  1 reset then enable=1, readdata=32'h3, waitrequest=0 -> avm_read pulses 1 cycle
//    every 10 cycles, key_state stays 2'b00, no press/release pulses.
//  2 readdata 32'h3 -> 32'h2 held -> after 3rd sample key_state=2'b01,
//    key_press=2'b01 one cycle; 2 samples of 32'h2 then 32'h3 -> no change.
//  3 key 0 pressed then readdata back to 32'h3 for 3 polls -> key_release=2'b01
//    one cycle, key_state=2'b00.
//  4 waitrequest held high 25 cycles -> avm_read stays 1, address 0, one capture
//    only; expired timer causes next read immediately after return to IDLE.
//  5 enable=0 during REQ -> read completes, sample_valid once, then no avm_read.
//  6 reset_n low during WAIT -> avm_read=0, outputs 0; after release polling
//    restarts from timer 0 and debounce from zero.

Source files
------------

// File: rtl/doodlejump_key_poller_if.sv
// Avalon-MM read bus between the key poller (master) and the key PIO (slave).
//   avm_address      master -> slave   word address of the PIO data register
//   avm_read         master -> slave   read request, held while avm_waitrequest is high
//   avm_waitrequest  slave -> master   stall
//   avm_readdata     slave -> master   registered read data, valid READ_LATENCY cycles
//                                      after the accept edge
interface doodlejump_key_poller_if #(
    parameter int unsigned ADDR_W = 2
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/doodlejump_key_poller.sv
// Periodically reads the key PIO data register over Avalon-MM and turns the raw
// pushbutton bits into debounced key state plus one-cycle press/release pulses.
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   enable       1: polling runs; 0: no new reads are issued
//   avm          Avalon-MM read master (address, read, waitrequest, readdata)
//   key_state    debounced key state, 1 = pressed
//   key_press    one-cycle pulse per bit on a debounced 0->1
//   key_release  one-cycle pulse per bit on a debounced 1->0
//   sample_valid one-cycle pulse while a captured sample is being debounced
module doodlejump_key_poller #(
    parameter int unsigned NKEYS        = 2,
    parameter int unsigned ADDR_W       = 2,
    parameter int unsigned KEY_ADDR     = 0,
    parameter int unsigned POLL_CYCLES  = 50000,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned DEBOUNCE_CNT = 4,
    parameter int unsigned ACTIVE_LOW   = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    doodlejump_key_poller_if.master avm,
    output logic [NKEYS-1:0]       key_state,
    output logic [NKEYS-1:0]       key_press,
    output logic [NKEYS-1:0]       key_release,
    output logic                   sample_valid
);

    localparam int unsigned TimerW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int unsigned LatW   = $clog2(READ_LATENCY + 1);
    localparam int unsigned DebW   = $clog2(DEBOUNCE_CNT) + 1;

    localparam logic [TimerW-1:0] TimerLast = TimerW'(POLL_CYCLES - 1);
    localparam logic [LatW-1:0]   LatLast   = LatW'(READ_LATENCY - 1);
    localparam logic [DebW-1:0]   DebLast   = DebW'(DEBOUNCE_CNT - 1);
    localparam logic [NKEYS-1:0]  RawInv    = (ACTIVE_LOW != 0) ? {NKEYS{1'b1}} : {NKEYS{1'b0}};

    typedef enum logic [1:0] {StIdle, StReq, StWait, StCapture} state_e;

    state_e            state_q;
    logic [TimerW-1:0] timer_q;
    logic              expired_q;
    logic              read_q;
    logic [LatW-1:0]   lat_q;
    logic [NKEYS-1:0]  raw_q;
    logic [DebW-1:0]   deb_q [NKEYS];

    logic timer_wrap;
    logic start_read;

    assign timer_wrap = enable && (timer_q == TimerLast);
    assign start_read = (state_q == StIdle) && expired_q && enable;

    assign avm.avm_read    = read_q;
    assign avm.avm_address = ADDR_W'(KEY_ADDR);

    // Only the key bits of the data register matter.
    logic unused_readdata;
    assign unused_readdata = ^avm.avm_readdata[31:NKEYS];

    // Poll timer; the expiry flag holds at most one pending poll. A new wrap wins
    // over a same-cycle clear so that expiry is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            if (!enable || timer_wrap) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + 1'b1;
            end
            if (timer_wrap) begin
                expired_q <= 1'b1;
            end else if (start_read) begin
                expired_q <= 1'b0;
            end
        end
    end

    // Read transaction FSM with debounce applied while leaving StCapture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            read_q       <= 1'b0;
            lat_q        <= '0;
            raw_q        <= '0;
            sample_valid <= 1'b0;
            key_state    <= '0;
            key_press    <= '0;
            key_release  <= '0;
            for (int i = 0; i < NKEYS; i++) begin
                deb_q[i] <= '0;
            end
        end else begin
            sample_valid <= 1'b0;
            key_press    <= '0;
            key_release  <= '0;
            unique case (state_q)
                StIdle: begin
                    if (start_read) begin
                        state_q <= StReq;
                        read_q  <= 1'b1;
                    end
                end
                StReq: begin
                    if (!avm.avm_waitrequest) begin
                        state_q <= StWait;
                        read_q  <= 1'b0;
                        lat_q   <= '0;
                    end
                end
                StWait: begin
                    // Readdata is valid READ_LATENCY cycles after the accept edge.
                    if (lat_q == LatLast) begin
                        raw_q        <= avm.avm_readdata[NKEYS-1:0] ^ RawInv;
                        sample_valid <= 1'b1;
                        state_q      <= StCapture;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                StCapture: begin
                    for (int i = 0; i < NKEYS; i++) begin
                        if (raw_q[i] == key_state[i]) begin
                            deb_q[i] <= '0;
                        end else if (deb_q[i] == DebLast) begin
                            deb_q[i]       <= '0;
                            key_state[i]   <= raw_q[i];
                            key_press[i]   <= raw_q[i];
                            key_release[i] <= ~raw_q[i];
                        end else begin
                            deb_q[i] <= deb_q[i] + 1'b1;
                        end
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
